// File: rtl/issue_scoreboard.sv
// issue_scoreboard: issue control between ID and the EXE pipes.
// Tracks pending GPR writes, reserves write-back slots for fixed-latency
// pipes, blocks on the single iterative pipe and makes a one-cycle issue
// decision for the instruction held in ID.
// Optional feature: define BYPASS_WB_EN to treat a register that is being
// written back this cycle as forwarded (not a hazard in that cycle).
module issue_scoreboard #(
   parameter int NUM_REGS  = 32,
   parameter int NUM_PIPES = 4,
   parameter int LAT_W     = 4,
   parameter logic [NUM_PIPES*LAT_W-1:0] PIPE_LAT = {4'd0, 4'd3, 4'd2, 4'd1},
   parameter int MAX_LAT   = 8,
   localparam int RW       = $clog2(NUM_REGS)
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 stall,
   input  logic                 flush,
   input  logic                 id_valid,
   input  logic [NUM_PIPES-1:0] id_pipe,
   input  logic [RW-1:0]        id_rd,
   input  logic                 id_rd_wr,
   input  logic [RW-1:0]        id_a1,
   input  logic [RW-1:0]        id_a2,
   input  logic                 id_use_a1,
   input  logic                 id_use_a2,
   input  logic                 wb_en,
   input  logic [RW-1:0]        wb_rd,
   input  logic                 iter_done,
   output logic                 issue,
   output logic                 sb_conflict,
   output logic                 wb_conflict,
   output logic                 iter_busy,
   output logic [NUM_REGS-1:0]  pending
);

   logic [MAX_LAT-1:0]  slot;
   logic [MAX_LAT-1:0]  slot_nxt;
   logic [NUM_REGS-1:0] pending_nxt;
   logic [NUM_REGS-1:0] pend_eff;
   logic                iter_busy_nxt;
   logic                one_hot;
   logic [LAT_W-1:0]    sel_lat;
   logic                is_iter;
   logic                is_fixed;
   logic                slot_hit;

   // Decode the target pipe: one-hot check and latency of the selected pipe
   always_comb begin
      one_hot = (id_pipe != '0) && ((id_pipe & (id_pipe - 1'b1)) == '0);
      sel_lat = '0;
      for (int i = 0; i < NUM_PIPES; i++) begin
         if (id_pipe[i]) sel_lat = sel_lat | PIPE_LAT[i*LAT_W +: LAT_W];
      end
      is_iter  = one_hot && (sel_lat == '0);
      is_fixed = one_hot && (sel_lat != '0);
      // slot[L] is the bit that lands in slot[L-1] after this cycle's shift;
      // L == MAX_LAT looks beyond the register and is always free
      slot_hit = 1'b0;
      for (int i = 1; i < MAX_LAT; i++) begin
         if (int'(sel_lat) == i) slot_hit = slot[i];
      end
   end

   // Hazard detection and the issue decision
   always_comb begin
      pend_eff = pending;
`ifdef BYPASS_WB_EN
      // The WB value is forwarded, so the register is already readable
      if (wb_en) pend_eff[wb_rd] = 1'b0;
`endif
      sb_conflict = id_valid && one_hot &&
                    ((pend_eff[id_a1] && id_use_a1) ||
                     (pend_eff[id_a2] && id_use_a2) ||
                     (pend_eff[id_rd] && id_rd_wr));
      wb_conflict = id_valid && is_fixed && slot_hit;
      issue       = id_valid && one_hot && !stall && !flush &&
                    !sb_conflict && !wb_conflict && !iter_busy;
   end

   // Next-state: scoreboard bits (set beats clear), WB slot shift, iterative busy
   always_comb begin
      pending_nxt = pending;
      if (wb_en) pending_nxt[wb_rd] = 1'b0;
      if (issue && id_rd_wr && (id_rd != '0)) pending_nxt[id_rd] = 1'b1;

      slot_nxt = slot >> 1;
      if (issue && is_fixed && id_rd_wr) begin
         for (int i = 0; i < MAX_LAT; i++) begin
            if (int'(sel_lat) == i + 1) slot_nxt[i] = 1'b1;
         end
      end

      iter_busy_nxt = iter_busy;
      if (issue && is_iter) iter_busy_nxt = 1'b1;
      else if (iter_done)   iter_busy_nxt = 1'b0;
   end

   // State registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pending   <= '0;
         slot      <= '0;
         iter_busy <= 1'b0;
      end else begin
         pending   <= pending_nxt;
         slot      <= slot_nxt;
         iter_busy <= iter_busy_nxt;
      end
   end

endmodule

// File: tb/tb_issue_scoreboard.sv
// Directed, table-driven bench for issue_scoreboard (default parameters:
// pipe0 L=1, pipe1 L=2, pipe2 L=3, pipe3 iterative).
module tb_issue_scoreboard;

   localparam logic [3:0] ALU = 4'b0001;
   localparam logic [3:0] P2  = 4'b0010;
   localparam logic [3:0] MUL = 4'b0100;
   localparam logic [3:0] DIV = 4'b1000;
`ifdef BYPASS_WB_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst_n;
   logic        stall, flush, id_valid, id_rd_wr, id_use_a1, id_use_a2;
   logic [3:0]  id_pipe;
   logic [4:0]  id_rd, id_a1, id_a2, wb_rd;
   logic        wb_en, iter_done;
   logic        issue, sb_conflict, wb_conflict, iter_busy;
   logic [31:0] pending;

   int n_chk  = 0;
   int n_fail = 0;

   typedef struct {
      logic        st, fl, vl;
      logic [3:0]  pipe;
      logic [4:0]  rd;
      logic        wr;
      logic [4:0]  a1;
      logic        u1;
      logic [4:0]  a2;
      logic        u2;
      logic        wbe;
      logic [4:0]  wbrd;
      logic        done;
      logic        e_issue, e_sb, e_wb, e_busy;
      logic [31:0] e_pend;
   } vec_t;

   vec_t vq[$];

   issue_scoreboard dut (
      .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush),
      .id_valid(id_valid), .id_pipe(id_pipe), .id_rd(id_rd), .id_rd_wr(id_rd_wr),
      .id_a1(id_a1), .id_a2(id_a2), .id_use_a1(id_use_a1), .id_use_a2(id_use_a2),
      .wb_en(wb_en), .wb_rd(wb_rd), .iter_done(iter_done),
      .issue(issue), .sb_conflict(sb_conflict), .wb_conflict(wb_conflict),
      .iter_busy(iter_busy), .pending(pending)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s (step %0d): got %h, expected %h", name, idx, act, exp);
      end
   endtask

   task automatic add(input logic st, fl, vl, input logic [3:0] pipe, input logic [4:0] rd,
                      input logic wr, input logic [4:0] a1, input logic u1,
                      input logic [4:0] a2, input logic u2, input logic wbe,
                      input logic [4:0] wbrd, input logic done,
                      input logic ei, esb, ewb, ebusy, input logic [31:0] epend);
      vec_t v;
      v.st = st; v.fl = fl; v.vl = vl; v.pipe = pipe; v.rd = rd; v.wr = wr;
      v.a1 = a1; v.u1 = u1; v.a2 = a2; v.u2 = u2; v.wbe = wbe; v.wbrd = wbrd;
      v.done = done; v.e_issue = ei; v.e_sb = esb; v.e_wb = ewb; v.e_busy = ebusy;
      v.e_pend = epend;
      vq.push_back(v);
   endtask

   task automatic drive(input vec_t v);
      stall = v.st; flush = v.fl; id_valid = v.vl; id_pipe = v.pipe;
      id_rd = v.rd; id_rd_wr = v.wr; id_a1 = v.a1; id_use_a1 = v.u1;
      id_a2 = v.a2; id_use_a2 = v.u2; wb_en = v.wbe; wb_rd = v.wbrd;
      iter_done = v.done;
   endtask

   // Drive one vector just after a rising edge and check at the falling edge
   task automatic apply(input vec_t v, input int idx);
      @(posedge clk);
      #1;
      drive(v);
      @(negedge clk);
      chk("issue",       idx, 32'(issue),       32'(v.e_issue));
      chk("sb_conflict", idx, 32'(sb_conflict), 32'(v.e_sb));
      chk("wb_conflict", idx, 32'(wb_conflict), 32'(v.e_wb));
      chk("iter_busy",   idx, 32'(iter_busy),   32'(v.e_busy));
      chk("pending",     idx, pending,          v.e_pend);
   endtask

   initial begin
      vec_t idle;
      //   st fl vl pipe  rd wr a1 u1 a2 u2 wbe wbrd dn  iss sb wb bsy pend
      // RAW on x5 (read through a2), resolved by WB of x5
      add(0, 0, 0, 4'b0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 32'h0);
      add(0, 0, 1, ALU,  5, 1, 1, 1, 2, 1, 0, 0, 0,  1, 0, 0, 0, 32'h0);
      add(0, 0, 1, ALU,  0, 0, 3, 1, 5, 1, 0, 0, 0,  0, 1, 0, 0, 32'h20);
      add(0, 0, 1, ALU,  0, 0, 3, 1, 5, 1, 1, 5, 0,  BYP, !BYP, 0, 0, 32'h20);
      add(0, 0, 1, ALU,  0, 0, 3, 1, 5, 1, 0, 0, 0,  1, 0, 0, 0, 32'h0);
      // WB collision: MUL(L=3) then ALU(L=1) two cycles later
      add(0, 0, 1, MUL, 10, 1, 1, 1, 0, 0, 0, 0, 0,  1, 0, 0, 0, 32'h0);
      add(0, 0, 0, 4'b0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 32'h400);
      add(0, 0, 1, ALU, 11, 1, 1, 1, 0, 0, 0, 0, 0,  0, 0, 1, 0, 32'h400);
      add(0, 0, 1, ALU, 11, 1, 1, 1, 0, 0, 1, 10, 0, 1, 0, 0, 0, 32'h400);
      add(0, 0, 0, 4'b0, 0, 0, 0, 0, 0, 0, 1, 11, 0, 0, 0, 0, 0, 32'h800);
      // Iterative DIV holds an independent ALU until iter_done
      add(0, 0, 1, DIV, 12, 1, 1, 1, 0, 0, 0, 0, 0,  1, 0, 0, 0, 32'h0);
      add(0, 0, 1, ALU, 13, 1, 2, 1, 0, 0, 0, 0, 0,  0, 0, 0, 1, 32'h1000);
      add(0, 0, 1, ALU, 13, 1, 2, 1, 0, 0, 1, 12, 1, 0, 0, 0, 1, 32'h1000);
      add(0, 0, 1, ALU, 13, 1, 2, 1, 0, 0, 0, 0, 0,  1, 0, 0, 0, 32'h0);
      add(0, 0, 0, 4'b0, 0, 0, 0, 0, 0, 0, 1, 13, 1, 0, 0, 0, 0, 32'h2000);
      // x0 never pending; iter_done while idle ignored; set beats clear on x7
      add(0, 0, 1, ALU,  0, 1, 1, 1, 0, 0, 0, 0, 0,  1, 0, 0, 0, 32'h0);
      add(0, 0, 1, ALU,  8, 1, 0, 1, 0, 1, 0, 0, 0,  1, 0, 0, 0, 32'h0);
      add(0, 0, 1, ALU,  7, 1, 1, 1, 0, 0, 1, 7, 0,  1, 0, 0, 0, 32'h100);
      add(0, 0, 0, 4'b0, 0, 0, 0, 0, 0, 0, 1, 8, 0,  0, 0, 0, 0, 32'h180);
      add(0, 0, 0, 4'b0, 0, 0, 0, 0, 0, 0, 1, 7, 0,  0, 0, 0, 0, 32'h80);
      // flush keeps pending x9 and the MUL slot, which still blocks an ALU later
      add(0, 0, 1, MUL,  9, 1, 1, 1, 0, 0, 0, 0, 0,  1, 0, 0, 0, 32'h0);
      add(0, 1, 1, ALU, 14, 1, 1, 1, 0, 0, 0, 0, 0,  0, 0, 0, 0, 32'h200);
      add(0, 0, 1, ALU, 14, 1, 1, 1, 0, 0, 0, 0, 0,  0, 0, 1, 0, 32'h200);
      add(0, 0, 1, ALU, 14, 1, 1, 1, 0, 0, 1, 9, 0,  1, 0, 0, 0, 32'h200);
      add(0, 0, 0, 4'b0, 0, 0, 0, 0, 0, 0, 1, 14, 0, 0, 0, 0, 0, 32'h4000);
      // non-one-hot pipe suppresses everything; stall only blocks issue
      add(0, 0, 1, MUL, 15, 1, 1, 1, 0, 0, 0, 0, 0,  1, 0, 0, 0, 32'h0);
      add(0, 0, 1, 4'b0011, 15, 1, 15, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h8000);
      add(1, 0, 1, ALU, 16, 1, 15, 1, 0, 0, 0, 0, 0, 0, 1, 1, 0, 32'h8000);
      add(0, 0, 0, 4'b0, 0, 0, 0, 0, 0, 0, 1, 15, 0, 0, 0, 0, 0, 32'h8000);
      add(1, 0, 1, ALU, 16, 1, 1, 1, 0, 0, 0, 0, 0,  0, 0, 0, 0, 32'h0);
      // L=2 pipe followed by ALU: collision, then issue once the slot passes
      add(0, 0, 1, P2,  17, 1, 1, 1, 0, 0, 0, 0, 0,  1, 0, 0, 0, 32'h0);
      add(0, 0, 1, ALU, 18, 1, 1, 1, 0, 0, 0, 0, 0,  0, 0, 1, 0, 32'h20000);
      add(0, 0, 1, ALU, 18, 1, 1, 1, 0, 0, 1, 17, 0, 1, 0, 0, 0, 32'h20000);
      add(0, 0, 0, 4'b0, 0, 0, 0, 0, 0, 0, 1, 18, 0, 0, 0, 0, 0, 32'h40000);
      add(0, 0, 0, 4'b0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 32'h0);

      idle = vq[0];
      rst_n = 1'b0;
      drive(idle);
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("reset pending",   -1, pending, 32'h0);
      chk("reset iter_busy", -1, 32'(iter_busy), 32'h0);
      chk("reset issue",     -1, 32'(issue), 32'h0);
      rst_n = 1'b1;

      for (int i = 0; i < vq.size(); i++) apply(vq[i], i);

      // Asynchronous reset mid-run with x4 pending and the iterative pipe busy
      begin
         vec_t v;
         v = idle;
         v.vl = 1'b1; v.pipe = ALU; v.rd = 5'd4; v.wr = 1'b1; v.a1 = 5'd1; v.u1 = 1'b1;
         v.e_issue = 1'b1;
         apply(v, 100);
         v.pipe = DIV; v.rd = 5'd0; v.wr = 1'b0; v.e_pend = 32'h10;
         apply(v, 101);
      end
      @(posedge clk);
      #1;
      drive(idle);
      #1;
      chk("pre-reset pending",   102, pending, 32'h10);
      chk("pre-reset iter_busy", 102, 32'(iter_busy), 32'h1);
      rst_n = 1'b0;
      #1;
      chk("async reset pending",   103, pending, 32'h0);
      chk("async reset iter_busy", 103, 32'(iter_busy), 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      apply(idle, 104);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
